// File: rtl/ftdi_umft601a_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// ftdi_umft601a_reset_sequencer_if
// Bundles the control word and status/pin outputs of the UMFT601A reset
// sequencer so the sequencer and its host see one named bus.
//
// Signals:
//   ctrl_in[1:0]      host -> sequencer  bit0 reset_hold, bit1 fifo_inhibit
//   ftdi_reset_n      sequencer -> pin   active-low RESET_N drive
//   fifo_if_en        sequencer -> host  enable for the FT601 FIFO controller
//   ftdi_ready        sequencer -> host  high while READY
//   busy              sequencer -> host  high while ASSERT or SETTLE
//   reset_count[7:0]  sequencer -> host  saturating count of re-assertions
//
// Handshake: there is no valid/ready pair on this bus. ctrl_in is a level
// that is sampled on every clk edge; all outputs are levels that change only
// on clk edges.
//
// Modports:
//   master  the host side (drives ctrl_in)
//   slave   the sequencer side (drives the status/pin outputs)
// ----------------------------------------------------------------------------
interface ftdi_umft601a_reset_sequencer_if;
  logic [1:0] ctrl_in;
  logic       ftdi_reset_n;
  logic       fifo_if_en;
  logic       ftdi_ready;
  logic       busy;
  logic [7:0] reset_count;

  modport master (
    output ctrl_in,
    input  ftdi_reset_n,
    input  fifo_if_en,
    input  ftdi_ready,
    input  busy,
    input  reset_count
  );

  modport slave (
    input  ctrl_in,
    output ftdi_reset_n,
    output fifo_if_en,
    output ftdi_ready,
    output busy,
    output reset_count
  );
endinterface

// File: rtl/ftdi_umft601a_reset_sequencer.sv
// ----------------------------------------------------------------------------
// ftdi_umft601a_reset_sequencer
// Drives the RESET_N pin of an FTDI UMFT601A module. The pin is held low for
// RST_ASSERT_CYCLES clocks, optionally held there while the host asserts
// reset_hold, then released. After RST_SETTLE_CYCLES more clocks the FT601 is
// declared ready and the downstream FIFO bus controller may be enabled.
//
// Parameters:
//   RST_ASSERT_CYCLES  low time of RESET_N in clk cycles (1..65535)
//   RST_SETTLE_CYCLES  wait after release before READY (1..65535)
//
// Ports:
//   clk          single clock
//   reset        synchronous, active-high block reset
//   bus          sequencer side of ftdi_umft601a_reset_sequencer_if
//   o_dbg_state  current FSM state (ASSERT=0, HOLD=1, SETTLE=2, READY=3)
//
// Optional build macro:
//   FTDI_RST_CTRL_SYNC_EN  when defined, ctrl_in passes through a 2-flop
//                          synchronizer before use (+2 clk latency on every
//                          ctrl_in-driven change). When undefined, ctrl_in is
//                          treated as a same-clock-domain signal.
// ----------------------------------------------------------------------------
module ftdi_umft601a_reset_sequencer #(
  parameter int unsigned RST_ASSERT_CYCLES = 16,
  parameter int unsigned RST_SETTLE_CYCLES = 1000
) (
  input  logic                               clk,
  input  logic                               reset,
  ftdi_umft601a_reset_sequencer_if.slave     bus,
  output logic [1:0]                         o_dbg_state
);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  localparam logic [15:0] ASSERT_LOAD = 16'(RST_ASSERT_CYCLES);
  localparam logic [15:0] SETTLE_LOAD = 16'(RST_SETTLE_CYCLES);

  // Control word as seen by the FSM.
  logic [1:0] w_ctrl;
  logic       w_hold;

`ifdef FTDI_RST_CTRL_SYNC_EN
  logic [1:0] r_sync_meta;
  logic [1:0] r_sync_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_meta <= 2'b11;
      r_sync_out  <= 2'b11;
    end else begin
      r_sync_meta <= bus.ctrl_in;
      r_sync_out  <= r_sync_meta;
    end
  end

  assign w_ctrl = r_sync_out;
`else
  assign w_ctrl = bus.ctrl_in;
`endif

  assign w_hold = w_ctrl[0];

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_cnt;
  logic [15:0] w_next_cnt;
  logic        w_cnt_inc;
  logic [7:0]  r_reset_count;
  // fifo_inhibit is registered so it reaches fifo_if_en on the same edge a
  // reset_hold change reaches the state register.
  logic        r_inhibit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_ASSERT;
      r_cnt         <= ASSERT_LOAD;
      r_reset_count <= 8'd0;
      r_inhibit     <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_inhibit <= w_ctrl[1];
      if (w_cnt_inc && (r_reset_count != 8'hFF)) begin
        r_reset_count <= r_reset_count + 8'd1;
      end
    end
  end

  // r_cnt holds the number of cycles remaining in the current timed state,
  // including the present one; the state is left when it reads 1.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_ASSERT: begin
        // reset_hold is only looked at on the expiry cycle, so a hold pulse
        // can never cut the low time short.
        if (r_cnt <= 16'd1) begin
          w_next_state = w_hold ? ST_HOLD : ST_SETTLE;
          w_next_cnt   = SETTLE_LOAD;
        end else begin
          w_next_cnt = r_cnt - 16'd1;
        end
      end
      ST_HOLD: begin
        if (!w_hold) begin
          w_next_state = ST_SETTLE;
          w_next_cnt   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        // A new hold request wins over settle expiry.
        if (w_hold) begin
          w_next_state = ST_ASSERT;
          w_next_cnt   = ASSERT_LOAD;
          w_cnt_inc    = 1'b1;
        end else if (r_cnt <= 16'd1) begin
          w_next_state = ST_READY;
        end else begin
          w_next_cnt = r_cnt - 16'd1;
        end
      end
      ST_READY: begin
        if (w_hold) begin
          w_next_state = ST_ASSERT;
          w_next_cnt   = ASSERT_LOAD;
          w_cnt_inc    = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_ASSERT;
        w_next_cnt   = ASSERT_LOAD;
      end
    endcase
  end

  assign bus.ftdi_reset_n = (r_state == ST_SETTLE) || (r_state == ST_READY);
  assign bus.fifo_if_en   = (r_state == ST_READY) && !r_inhibit;
  assign bus.ftdi_ready   = (r_state == ST_READY);
  assign bus.busy         = (r_state == ST_ASSERT) || (r_state == ST_SETTLE);
  assign bus.reset_count  = r_reset_count;
  assign o_dbg_state      = r_state;

endmodule
